// File: rtl/sys_arr_pkg.sv
// Shared constants and types for the systolic-array sparse front end.
package sys_arr_pkg;

  localparam int DW  = 16;
  localparam int N   = 4;
  localparam int IND = $clog2(N);

  typedef enum logic {ENC_IDLE, ENC_EMIT} enc_state_t;

endpackage

// File: rtl/sysarr_lsb_finder.sv
// Lowest-set-bit locator.
// Reports whether any bit of the mask is set and the index of the lowest one.
// Purely combinational, so downstream index matchers can reuse it.
module sysarr_lsb_finder #(
  parameter int N   = 4,
  parameter int IND = $clog2(N)
) (
  input  logic [N-1:0]   mask,
  output logic           found,
  output logic [IND-1:0] idx
);

  // Scan from the top down so that the lowest set bit is the last one written.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i]) begin
        found = 1'b1;
        idx   = IND'(i);
      end
    end
  end

endmodule

// File: rtl/sysarr_sparse_encoder.sv
// Sparse row encoder.
// Latches one dense row, then emits one (value, column, end) entry per
// non-stalled cycle onto the index FIFO load port, lowest column first.
// A row with no non-zero elements still produces a single end-of-row entry,
// so downstream logic always sees a row terminator.
module sysarr_sparse_encoder
  import sys_arr_pkg::*;
#(
  parameter int DW  = sys_arr_pkg::DW,
  parameter int N   = sys_arr_pkg::N,
  parameter int IND = sys_arr_pkg::IND
) (
  input  logic            clk,
  input  logic            nRST,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*DW-1:0] in_row,
  input  logic            fifo_full,
  output logic            load,
  output logic [DW-1:0]   load_vals,
  output logic [IND-1:0]  load_inds,
  output logic            load_ends,
  output logic [IND:0]    row_nnz
);

  enc_state_t      state_q, state_d;
  logic [N*DW-1:0] row_q, row_d;
  logic [N-1:0]    mask_q, mask_d;
  logic [IND:0]    nnz_q, nnz_d;

  logic [N-1:0]    in_mask;
  logic [IND:0]    in_nnz;
  logic            lsb_found;
  logic [IND-1:0]  lsb_idx;
  logic [N-1:0]    mask_rest;
  logic [DW-1:0]   cur_val;
  logic            emitting;

  // Non-zero mask and population count of the row on the input port.
  always_comb begin
    in_mask = '0;
    in_nnz  = '0;
    for (int c = 0; c < N; c++) begin
      in_mask[c] = (in_row[c*DW +: DW] != '0);
      in_nnz     = in_nnz + (IND+1)'(in_mask[c]);
    end
  end

  sysarr_lsb_finder #(
    .N   (N),
    .IND (IND)
  ) u_lsb_finder (
    .mask  (mask_q),
    .found (lsb_found),
    .idx   (lsb_idx)
  );

  // Pending entry: lowest remaining column, and the mask once that column is consumed.
  always_comb begin
    mask_rest = mask_q & (mask_q - N'(1));
    cur_val   = lsb_found ? row_q[lsb_idx*DW +: DW] : '0;
  end

  // Next-state logic: accept in IDLE, retire one entry per non-stalled EMIT cycle.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    mask_d  = mask_q;
    nnz_d   = nnz_q;
    case (state_q)
      ENC_IDLE: begin
        if (in_valid) begin
          row_d   = in_row;
          mask_d  = in_mask;
          nnz_d   = in_nnz;
          state_d = ENC_EMIT;
        end
      end
      ENC_EMIT: begin
        if (!fifo_full) begin
          mask_d = mask_rest;
          if (mask_rest == '0) begin
            state_d = ENC_IDLE;
          end
        end
      end
      default: state_d = ENC_IDLE;
    endcase
  end

  // State, latched row, remaining mask and non-zero count; reset discards any partial row.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q <= ENC_IDLE;
      row_q   <= '0;
      mask_q  <= '0;
      nnz_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      mask_q  <= mask_d;
      nnz_q   <= nnz_d;
    end
  end

  // Load port is decoded from state, mask, row and fifo_full only, never from the input port.
  always_comb begin
    emitting  = (state_q == ENC_EMIT);
    in_ready  = (state_q == ENC_IDLE);
    load      = emitting && !fifo_full;
    load_vals = emitting ? cur_val : '0;
    load_inds = emitting ? lsb_idx : '0;
    load_ends = emitting && (mask_rest == '0);
    row_nnz   = nnz_q;
  end

endmodule

// File: tb/tb_sysarr_sparse_encoder.sv
// Directed bench for the sparse row encoder.
// Each step drives one cycle of inputs and checks the full output vector
// against a hand-computed value; a FIFO model collects every load and
// rebuilds dense rows so whole rows can be compared as well.
module tb_sysarr_sparse_encoder;

  localparam int DW  = 16;
  localparam int N   = 4;
  localparam int IND = 2;

  typedef struct packed {
    logic [DW-1:0]  val;
    logic [IND-1:0] ind;
    logic           last;
  } entry_t;

  logic            clk = 1'b0;
  logic            nRST = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [N*DW-1:0] in_row = '0;
  logic            fifo_full = 1'b0;
  logic            load;
  logic [DW-1:0]   load_vals;
  logic [IND-1:0]  load_inds;
  logic            load_ends;
  logic [IND:0]    row_nnz;

  int vectors = 0;
  int miscompares = 0;

  entry_t fifo_q[$];

  logic               stall_prev = 1'b0;
  logic [DW+IND:0]    stall_saved = '0;

  sysarr_sparse_encoder dut (
    .clk       (clk),
    .nRST      (nRST),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_row    (in_row),
    .fifo_full (fifo_full),
    .load      (load),
    .load_vals (load_vals),
    .load_inds (load_inds),
    .load_ends (load_ends),
    .row_nnz   (row_nnz)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // FIFO model: stores every accepted write; shares the encoder's reset.
  always @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      fifo_q.delete();
    end else if (load) begin
      fifo_q.push_back('{val: load_vals, ind: load_inds, last: load_ends});
    end
  end

  // Protocol watch: no load while idle, and a stalled entry must not move.
  always @(negedge clk) begin
    if (in_ready) begin
      vectors++;
      assert (load === 1'b0) else begin
        miscompares++;
        $error("[TB] FAIL idle_load observed=%0b expected=0", load);
      end
    end
    if (stall_prev && fifo_full && !in_ready) begin
      vectors++;
      assert ({load, load_vals, load_inds, load_ends} === {1'b0, stall_saved}) else begin
        miscompares++;
        $error("[TB] FAIL stall_hold observed=%h expected=%h",
               {load, load_vals, load_inds, load_ends}, {1'b0, stall_saved});
      end
    end
    stall_prev  = fifo_full && !in_ready && nRST;
    stall_saved = {load_vals, load_inds, load_ends};
  end

  function automatic logic [N*DW-1:0] mk_row(input logic [DW-1:0] c0, input logic [DW-1:0] c1,
                                             input logic [DW-1:0] c2, input logic [DW-1:0] c3);
    return {c3, c2, c1, c0};
  endfunction

  // One cycle: wait for the edge, drive the inputs, let combinational outputs settle.
  task automatic applyStimulus(input logic v, input logic [N*DW-1:0] row, input logic full);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_row    = row;
    fifo_full = full;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic rdy, input logic ld,
                             input logic [DW-1:0] v, input logic [IND-1:0] i,
                             input logic e, input logic [IND:0] nnz);
    logic [DW+IND+IND+3:0] obs, exp;
    obs = {in_ready, load, load_vals, load_inds, load_ends, row_nnz};
    exp = {rdy, ld, v, i, e, nnz};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h (rdy,load,val,ind,end,nnz)", tag, obs, exp);
    end
  endtask

  // Pop one row's worth of entries from the FIFO model and rebuild the dense row.
  task automatic checkRow(input string tag, input logic [N*DW-1:0] exp_row, input int exp_cnt);
    logic [N*DW-1:0] rebuilt;
    int   cnt;
    logic seen_end;
    entry_t en;
    rebuilt  = '0;
    cnt      = 0;
    seen_end = 1'b0;
    for (int k = 0; k <= N; k++) begin
      if (!seen_end && fifo_q.size() > 0) begin
        en = fifo_q.pop_front();
        rebuilt[en.ind*DW +: DW] = en.val;
        seen_end = en.last;
        cnt++;
      end
    end
    vectors++;
    assert (rebuilt === exp_row) else begin
      miscompares++;
      $error("[TB] FAIL %s_row observed=%h expected=%h", tag, rebuilt, exp_row);
    end
    vectors++;
    assert ({seen_end, cnt} === {1'b1, exp_cnt}) else begin
      miscompares++;
      $error("[TB] FAIL %s_count observed=%0b/%0d expected=1/%0d", tag, seen_end, cnt, exp_cnt);
    end
  endtask

  // Directed sequence.
  initial begin
    logic [N*DW-1:0] row_a, row_b;

    #1;
    checkOutput("reset", 1, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #1 nRST = 1'b1;

    $display("[TB] test 1: sparse row {5,0,7,0}");
    row_a = mk_row(5, 0, 7, 0);
    applyStimulus(1, row_a, 0); checkOutput("t1_accept", 1, 0, 0, 0, 0, 0);
    applyStimulus(0, '0, 0);    checkOutput("t1_load0",  0, 1, 5, 0, 0, 2);
    applyStimulus(0, '0, 0);    checkOutput("t1_load1",  0, 1, 7, 2, 1, 2);
    applyStimulus(0, '0, 0);    checkOutput("t1_idle",   1, 0, 0, 0, 0, 2);
    checkRow("t1", row_a, 2);

    $display("[TB] test 2: all-zero row");
    applyStimulus(1, '0, 0);    checkOutput("t2_accept", 1, 0, 0, 0, 0, 2);
    applyStimulus(0, '0, 0);    checkOutput("t2_load",   0, 1, 0, 0, 1, 0);
    applyStimulus(0, '0, 0);    checkOutput("t2_idle",   1, 0, 0, 0, 0, 0);
    checkRow("t2", '0, 1);

    $display("[TB] test 3: dense row {1,2,3,4}");
    row_a = mk_row(1, 2, 3, 4);
    applyStimulus(1, row_a, 0); checkOutput("t3_accept", 1, 0, 0, 0, 0, 0);
    applyStimulus(0, '0, 0);    checkOutput("t3_load0",  0, 1, 1, 0, 0, 4);
    applyStimulus(0, '0, 0);    checkOutput("t3_load1",  0, 1, 2, 1, 0, 4);
    applyStimulus(0, '0, 0);    checkOutput("t3_load2",  0, 1, 3, 2, 0, 4);
    applyStimulus(0, '0, 0);    checkOutput("t3_load3",  0, 1, 4, 3, 1, 4);
    applyStimulus(0, '0, 0);    checkOutput("t3_idle",   1, 0, 0, 0, 0, 4);
    checkRow("t3", row_a, 4);

    $display("[TB] test 4: stall on fifo_full");
    row_a = mk_row(0, 9, 0, 3);
    applyStimulus(1, row_a, 0); checkOutput("t4_accept", 1, 0, 0, 0, 0, 4);
    applyStimulus(0, '0, 1);    checkOutput("t4_stall0", 0, 0, 9, 1, 0, 2);
    applyStimulus(0, '0, 1);    checkOutput("t4_stall1", 0, 0, 9, 1, 0, 2);
    applyStimulus(0, '0, 1);    checkOutput("t4_stall2", 0, 0, 9, 1, 0, 2);
    applyStimulus(0, '0, 0);    checkOutput("t4_load0",  0, 1, 9, 1, 0, 2);
    applyStimulus(0, '0, 0);    checkOutput("t4_load1",  0, 1, 3, 3, 1, 2);
    applyStimulus(0, '0, 0);    checkOutput("t4_idle",   1, 0, 0, 0, 0, 2);
    vectors++;
    assert (fifo_q.size() === 2) else begin
      miscompares++;
      $error("[TB] FAIL t4_depth observed=%0d expected=2", fifo_q.size());
    end
    checkRow("t4", row_a, 2);

    $display("[TB] test 5: second row offered during EMIT");
    row_a = mk_row(6, 0, 0, 8);
    row_b = mk_row(0, 5, 0, 0);
    applyStimulus(1, row_a, 0); checkOutput("t5_acceptA", 1, 0, 0, 0, 0, 2);
    applyStimulus(1, row_b, 0); checkOutput("t5_loadA0",  0, 1, 6, 0, 0, 2);
    applyStimulus(1, row_b, 0); checkOutput("t5_loadA1",  0, 1, 8, 3, 1, 2);
    applyStimulus(1, row_b, 0); checkOutput("t5_acceptB", 1, 0, 0, 0, 0, 2);
    applyStimulus(0, '0, 0);    checkOutput("t5_loadB0",  0, 1, 5, 1, 1, 1);
    applyStimulus(0, '0, 0);    checkOutput("t5_idle",    1, 0, 0, 0, 0, 1);
    checkRow("t5a", row_a, 2);
    checkRow("t5b", row_b, 1);

    $display("[TB] test 6: reset mid-row");
    row_a = mk_row(4, 4, 4, 4);
    applyStimulus(1, row_a, 0); checkOutput("t6_accept", 1, 0, 0, 0, 0, 1);
    applyStimulus(0, '0, 0);    checkOutput("t6_load0",  0, 1, 4, 0, 0, 4);
    #1 nRST = 1'b0;
    #1 checkOutput("t6_reset", 1, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1 nRST = 1'b1;
    row_a = mk_row(0, 0, 2, 0);
    applyStimulus(1, row_a, 0); checkOutput("t6_accept2", 1, 0, 0, 0, 0, 0);
    applyStimulus(0, '0, 0);    checkOutput("t6_load2",   0, 1, 2, 2, 1, 1);
    applyStimulus(0, '0, 0);    checkOutput("t6_idle",    1, 0, 0, 0, 0, 1);
    checkRow("t6", row_a, 1);
    vectors++;
    assert (fifo_q.size() === 0) else begin
      miscompares++;
      $error("[TB] FAIL t6_leftover observed=%0d expected=0", fifo_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
